// File: rtl/time_set_ctrl.sv
// Button-driven hh:mm edit controller: mode walks hours -> minutes -> commit, inc/dec step the field.
// Define TIME_SET_AUTO_REPEAT_EN to enable auto-repeat on held inc/dec buttons.
module time_set_ctrl #(
    parameter int REPEAT_DELAY   = 50000000,
    parameter int REPEAT_PERIOD  = 10000000,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] cur_hours,
    input  logic [6:0] cur_minutes,
    output logic       set,
    output logic [4:0] set_hours,
    output logic [6:0] set_minutes,
    output logic [1:0] edit_field
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, EDIT_HR, EDIT_MIN, COMMIT} state_t;

    generate
        if (TIMEOUT_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
            $error("time_set_ctrl: cycle-count parameters must be at least 1");
        end
    endgenerate

    // Bit 0 = mode, bit 1 = inc, bit 2 = dec.
    logic [2:0]       w_raw;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_prev;
    logic [2:0]       r_lock;
    logic [1:0]       r_fill;
    logic [2:0]       w_press;
    state_t           r_state;
    logic [TMO_W-1:0] r_tmo;
    logic             r_set;
    logic [4:0]       r_hours;
    logic [6:0]       r_minutes;
    logic [1:0]       r_field;
    logic             w_mode;
    logic             w_inc_press;
    logic             w_dec_press;
    logic             w_editing;
    logic             w_up;
    logic             w_down;

    assign w_raw = {btn_dec, btn_inc, btn_mode};

    // r_lock keeps a button that was high across reset from counting until it is seen low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_lock  <= '1;
            r_fill  <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_fill  <= {r_fill[0], 1'b1};
            r_lock  <= r_lock & ~({3{r_fill[1]}} & ~r_sync2);
        end
    end

    assign w_press     = r_sync2 & ~r_prev & ~r_lock;
    assign w_mode      = w_press[0];
    assign w_inc_press = w_press[1] & ~w_press[2] & ~w_mode;
    assign w_dec_press = w_press[2] & ~w_press[1] & ~w_mode;
    assign w_editing   = (r_state == EDIT_HR) || (r_state == EDIT_MIN);

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

    logic [2:0]       w_level;
    logic             w_hold_inc;
    logic             w_hold_dec;
    logic             w_hold;
    logic             w_rep_step;
    logic [REP_W-1:0] r_rep;
    logic [REP_W-1:0] w_rep_next;

    assign w_level    = r_sync2 & ~r_lock;
    assign w_hold_inc = w_level[1] & ~w_level[2];
    assign w_hold_dec = w_level[2] & ~w_level[1];
    assign w_hold     = w_hold_inc | w_hold_dec;
    assign w_rep_next = r_rep + REP_W'(1);
    assign w_rep_step = w_editing & w_hold & ~w_press[1] & ~w_press[2] &
                        ((w_rep_next == REP_W'(REPEAT_DELAY)) ||
                         (w_rep_next == REP_W'(REPEAT_DELAY + REPEAT_PERIOD)));

    // Counts held cycles since the press; reloads to REPEAT_DELAY after each periodic step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rep <= '0;
        end else if (!w_editing || !w_hold || w_press[1] || w_press[2]) begin
            r_rep <= '0;
        end else if (w_rep_next == REP_W'(REPEAT_DELAY + REPEAT_PERIOD)) begin
            r_rep <= REP_W'(REPEAT_DELAY);
        end else begin
            r_rep <= w_rep_next;
        end
    end

    assign w_up   = w_inc_press | (w_rep_step & w_hold_inc & ~w_mode);
    assign w_down = w_dec_press | (w_rep_step & w_hold_dec & ~w_mode);
`else
    assign w_up   = w_inc_press;
    assign w_down = w_dec_press;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_tmo     <= '0;
            r_set     <= 1'b0;
            r_hours   <= '0;
            r_minutes <= '0;
            r_field   <= 2'b00;
        end else begin
            r_set <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tmo <= '0;
                    if (w_mode) begin
                        r_state   <= EDIT_HR;
                        r_field   <= 2'b01;
                        r_hours   <= cur_hours;
                        r_minutes <= cur_minutes;
                    end
                end
                EDIT_HR: begin
                    if (w_mode) begin
                        r_state <= EDIT_MIN;
                        r_field <= 2'b10;
                        r_tmo   <= '0;
                    end else if (w_up || w_down) begin
                        r_tmo <= '0;
                        if (w_up) r_hours <= (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
                        else      r_hours <= (r_hours == 5'd0) ? 5'd23 : r_hours - 5'd1;
                    end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state <= IDLE;
                        r_field <= 2'b00;
                        r_tmo   <= '0;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                EDIT_MIN: begin
                    if (w_mode) begin
                        r_state <= COMMIT;
                        r_field <= 2'b00;
                        r_set   <= 1'b1;
                        r_tmo   <= '0;
                    end else if (w_up || w_down) begin
                        r_tmo <= '0;
                        if (w_up) r_minutes <= (r_minutes == 7'd59) ? 7'd0 : r_minutes + 7'd1;
                        else      r_minutes <= (r_minutes == 7'd0) ? 7'd59 : r_minutes - 7'd1;
                    end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state <= IDLE;
                        r_field <= 2'b00;
                        r_tmo   <= '0;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_field <= 2'b00;
                    r_tmo   <= '0;
                end
            endcase
        end
    end

    assign set         = r_set;
    assign set_hours   = r_hours;
    assign set_minutes = r_minutes;
    assign edit_field  = r_field;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: cycle-level behavioural model plus directed literal checks.
// Build with TIME_SET_AUTO_REPEAT_EN defined to exercise auto-repeat.
module tb_time_set_ctrl;
    localparam int TMO = 100;
    localparam int RD  = 20;
    localparam int RP  = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic [4:0] cur_hours = 5'd0;
    logic [6:0] cur_minutes = 7'd0;
    logic       set;
    logic [4:0] set_hours;
    logic [6:0] set_minutes;
    logic [1:0] edit_field;

    always #5 clk = ~clk;

    time_set_ctrl #(
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .cur_hours  (cur_hours),
        .cur_minutes(cur_minutes),
        .set        (set),
        .set_hours  (set_hours),
        .set_minutes(set_minutes),
        .edit_field (edit_field)
    );

    int n_total = 0;
    int n_pass  = 0;
    int set_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Behavioural model: 0 idle, 1 hours, 2 minutes, 3 commit.
    int m_st = 0, m_h = 0, m_m = 0, m_set = 0, m_idle = 0, m_n = 0;
    bit hist [3][4];
    bit lock [3];
    int rep_btn = 0, rep_t = 0;

    task automatic model_step();
        bit raw [3];
        bit press [3];
        bit level [3];
        bit mode, up, down;
        if (reset) begin
            m_st = 0; m_h = 0; m_m = 0; m_set = 0; m_idle = 0; m_n = 0;
            rep_btn = 0; rep_t = 0;
            for (int b = 0; b < 3; b++) begin
                lock[b] = 1'b1;
                for (int j = 0; j < 4; j++) hist[b][j] = 1'b0;
            end
            return;
        end
        raw[0] = btn_mode; raw[1] = btn_inc; raw[2] = btn_dec;
        m_n++;
        for (int b = 0; b < 3; b++) begin
            for (int j = 3; j > 0; j--) hist[b][j] = hist[b][j-1];
            hist[b][0] = raw[b];
            // The press is seen two samples after the raw input first reads high.
            press[b] = hist[b][2] && !hist[b][3] && !lock[b];
            level[b] = hist[b][2] && !lock[b];
            if (m_n >= 3 && !hist[b][2]) lock[b] = 1'b0;
        end
        mode = press[0];
        up   = press[1] && !press[2] && !mode;
        down = press[2] && !press[1] && !mode;
`ifdef TIME_SET_AUTO_REPEAT_EN
        if (m_st == 1 || m_st == 2) begin
            if (press[1] && !press[2]) begin
                rep_btn = 1; rep_t = 0;
            end else if (press[2] && !press[1]) begin
                rep_btn = 2; rep_t = 0;
            end else if (rep_btn != 0 && level[rep_btn] && !level[3-rep_btn]) begin
                rep_t++;
                if ((rep_t == RD || (rep_t > RD && (rep_t - RD) % RP == 0)) && !mode) begin
                    if (rep_btn == 1) up = 1'b1;
                    else down = 1'b1;
                end
            end else begin
                rep_btn = 0;
            end
        end else begin
            rep_btn = 0;
        end
`else
        if (level[1] && level[2]) rep_btn = 0;
`endif
        m_set = 0;
        case (m_st)
            0: if (mode) begin
                m_st = 1; m_h = cur_hours; m_m = cur_minutes; m_idle = 0;
            end
            1, 2: begin
                if (mode) begin
                    m_st = m_st + 1; m_idle = 0;
                    if (m_st == 3) m_set = 1;
                end else if (up || down) begin
                    m_idle = 0;
                    if (m_st == 1) m_h = (m_h + (up ? 1 : 23)) % 24;
                    else m_m = (m_m + (up ? 1 : 59)) % 60;
                end else begin
                    m_idle++;
                    if (m_idle == TMO) m_st = 0;
                end
            end
            default: m_st = 0;
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (set) set_cnt++;
        chk("set", int'(set), m_set);
        chk("hours", int'(set_hours), m_h);
        chk("minutes", int'(set_minutes), m_m);
        chk("field", int'(edit_field), (m_st == 1) ? 1 : (m_st == 2) ? 2 : 0);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // mask bit 0 = mode, bit 1 = inc, bit 2 = dec
    task automatic press(input logic [2:0] mask);
        btn_mode = mask[0]; btn_inc = mask[1]; btn_dec = mask[2];
        tick(4);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        tick(6);
        $display("press mask=%b field=%0d h=%0d m=%0d sets=%0d", mask, edit_field, set_hours, set_minutes, set_cnt);
    endtask

    initial begin
        bit found;
        reset = 1'b1; cur_hours = 5'd10; cur_minutes = 7'd30;
        tick(3);
        reset = 1'b0;
        tick(5);
        chk("rst_field", int'(edit_field), 0);
        chk("rst_hours", int'(set_hours), 0);
        chk("rst_set", int'(set), 0);

        press(3'b001);
        chk("e1_field", int'(edit_field), 1);
        chk("e1_hours", int'(set_hours), 10);
        chk("e1_min", int'(set_minutes), 30);
        press(3'b001);
        chk("e2_field", int'(edit_field), 2);
        press(3'b001);
        chk("c1_field", int'(edit_field), 0);
        chk("c1_sets", set_cnt, 1);
        chk("c1_hours", int'(set_hours), 10);
        chk("c1_min", int'(set_minutes), 30);

        cur_hours = 5'd23; cur_minutes = 7'd0;
        press(3'b001);
        chk("w_hours23", int'(set_hours), 23);
        press(3'b010);
        chk("wrap_hr_inc", int'(set_hours), 0);
        press(3'b001);
        press(3'b100);
        chk("wrap_min_dec", int'(set_minutes), 59);
        press(3'b001);
        chk("c2_sets", set_cnt, 2);

        cur_hours = 5'd5; cur_minutes = 7'd15;
        press(3'b001);
        press(3'b011);
        chk("modeinc_field", int'(edit_field), 2);
        chk("modeinc_hours", int'(set_hours), 5);
        press(3'b110);
        chk("incdec_min", int'(set_minutes), 15);
        press(3'b010);
        chk("inc_min", int'(set_minutes), 16);
        press(3'b100);
        press(3'b100);
        chk("dec_min", int'(set_minutes), 14);
        press(3'b001);
        chk("c3_sets", set_cnt, 3);

        // Timeout: enter hours edit and leave it alone.
        btn_mode = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (edit_field == 2'd1) found = 1'b1;
        end
        btn_mode = 1'b0;
        chk("tmo_entry", int'(found), 1);
        tick(99);
        chk("tmo_99", int'(edit_field), 1);
        tick(1);
        chk("tmo_100", int'(edit_field), 0);
        chk("tmo_sets", set_cnt, 3);
        $display("timeout field=%0d sets=%0d", edit_field, set_cnt);

        // Reset in the middle of a minutes edit.
        cur_hours = 5'd7; cur_minutes = 7'd20;
        press(3'b001);
        press(3'b001);
        press(3'b010);
        chk("pre_rst_min", int'(set_minutes), 21);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(5);
        chk("mid_rst_hours", int'(set_hours), 0);
        chk("mid_rst_min", int'(set_minutes), 0);
        chk("mid_rst_field", int'(edit_field), 0);
        chk("mid_rst_sets", set_cnt, 3);

        // Mode held through reset release must not count as a press.
        btn_mode = 1'b1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(10);
        chk("held_field", int'(edit_field), 0);
        btn_mode = 1'b0;
        tick(5);
        chk("rel_field", int'(edit_field), 0);
        press(3'b001);
        chk("repress_field", int'(edit_field), 1);
        chk("repress_hours", int'(set_hours), 7);
        press(3'b001);
        press(3'b001);
        chk("c4_sets", set_cnt, 4);

        // Hold inc for 40 cycles in a minutes edit starting at 0.
        cur_hours = 5'd0; cur_minutes = 7'd0;
        press(3'b001);
        press(3'b001);
        btn_inc = 1'b1;
        tick(40);
        btn_inc = 1'b0;
        tick(6);
`ifdef TIME_SET_AUTO_REPEAT_EN
        chk("hold_min", int'(set_minutes), 5);
`else
        chk("hold_min", int'(set_minutes), 1);
`endif
        $display("hold40 minutes=%0d", set_minutes);
        press(3'b001);
        chk("c5_sets", set_cnt, 5);
        tick(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter REPEAT_DELAY, default 50000000, meaning clk cycles an inc/dec button must be held before auto-repeat begins.
REQ-002 Parameter REPEAT_PERIOD, default 10000000, meaning clk cycles between auto-repeat steps.
REQ-003 Parameter TIMEOUT_CYCLES, default 500000000, meaning clk cycles without any accepted press before an edit is abandoned.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 btn_mode  input  1  raw mode button, level, asynchronous to clk, already debounced.
REQ-007 btn_inc  input  1  raw increment button, same properties as btn_mode.
REQ-008 btn_dec  input  1  raw decrement button, same properties as btn_mode.
REQ-009 cur_hours  input  5  running hour value 0..23, captured at edit entry.
REQ-010 cur_minutes  input  7  running minute value 0..59, captured at edit entry.
REQ-011 set  output  1  one-clk pulse commanding the counters to load set_hours/set_minutes.
REQ-012 set_hours  output  5  hour value to load, 0..23.
REQ-013 set_minutes  output  7  minute value to load, 0..59.
REQ-014 edit_field  output  2  00 idle, 01 editing hours, 10 editing minutes; 11 never driven.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer followed by a previous-value flop; a press is a synced 0->1 transition.
REQ-016 An action SHALL be registered on the clock edge at which the press is detected, i.e. on the 3rd rising clk edge at which the raw input is sampled high.
REQ-017 FSM states SHALL be IDLE, EDIT_HR, EDIT_MIN, COMMIT.
REQ-018 IDLE + mode press -> EDIT_HR; on that edge set_hours<=cur_hours and set_minutes<=cur_minutes.
REQ-019 EDIT_HR + mode press -> EDIT_MIN; EDIT_MIN + mode press -> COMMIT.
REQ-020 COMMIT SHALL last exactly one cycle, assert set=1 for that cycle only, then return to IDLE.
REQ-021 In EDIT_HR an inc press SHALL step set_hours +1 with 23->0 wrap; a dec press SHALL step -1 with 0->23 wrap.
REQ-022 In EDIT_MIN an inc press SHALL step set_minutes +1 with 59->0 wrap; a dec press SHALL step -1 with 0->59 wrap.
REQ-023 Inc/dec presses in IDLE or COMMIT SHALL be ignored.
REQ-024 Simultaneous inc and dec presses in the same cycle SHALL both be ignored.
REQ-025 A mode press in the same cycle as an inc/dec press SHALL take priority; the inc/dec press SHALL be dropped.
REQ-026 In EDIT_HR/EDIT_MIN, TIMEOUT_CYCLES consecutive cycles with no accepted press SHALL return the FSM to IDLE with no set pulse; set_hours/set_minutes retain their values.
REQ-027 Every accepted press SHALL restart the timeout counter.
REQ-028 set_hours/set_minutes SHALL hold their values whenever not being stepped or captured.
REQ-029 edit_field SHALL be a registered decode of the FSM state; COMMIT SHALL drive 00.

Reset
REQ-030 Reset SHALL force FSM=IDLE, set=0, set_hours=0, set_minutes=0, edit_field=00, and clear synchronizers, timeout and repeat counters.
REQ-031 Reset asserted mid-edit or during COMMIT SHALL suppress any set pulse.
REQ-032 A button held high through reset deassertion SHALL NOT be treated as a press until released and pressed again.

Configuration
REQ-033 Macro TIME_SET_AUTO_REPEAT_EN SHALL control auto-repeat.
REQ-034 With the macro defined, an inc or dec held alone in an edit state SHALL produce one step at the press, one more after REPEAT_DELAY cycles held, then one step every REPEAT_PERIOD cycles until release; each step restarts the timeout.
REQ-035 Without the macro, exactly one step SHALL occur per press regardless of hold time, and no repeat counter SHALL be instantiated.

Verification
REQ-036 Reset, cur_hours=10, cur_minutes=30; press mode x3 -> exactly one set pulse, one clk wide, set_hours=10, set_minutes=30, edit_field 01,10,00.
REQ-037 In EDIT_HR with set_hours=23, one inc press -> set_hours=0; in EDIT_MIN with set_minutes=0, one dec press -> set_minutes=59.
REQ-038 Inc and dec rising in the same cycle in EDIT_MIN=15 -> set_minutes stays 15; mode+inc in EDIT_HR -> EDIT_MIN, set_hours unchanged.
REQ-039 TIMEOUT_CYCLES=100, enter EDIT_HR, no presses -> IDLE at cycle 100, set never asserted.
REQ-040 Reset asserted during EDIT_MIN, then released -> IDLE, set_hours=0, set_minutes=0, no set pulse.
REQ-041 With TIME_SET_AUTO_REPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5, inc held 40 cycles in EDIT_MIN from 0 -> set_minutes=5; without the macro -> set_minutes=1.
